// File: rtl/instr_prefetch_if.sv
// Prefetch bus bundle: core-side redirect/instruction handshake plus memory request channel.
// The master side belongs to the prefetch stage; the slave side is the core and memory.
// No clock or reset lives here; those stay plain ports on the module.
interface instr_prefetch_if #(
  parameter int AW = 10
);
  // core side
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [15:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  // memory side
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_rdata;
  // performance
  logic [31:0]   stall_count;

  modport master (
    input  redirect, redirect_pc, instr_ready, mem_ack, mem_rdata,
    output instr, instr_pc, instr_valid, mem_req, mem_addr, stall_count
  );

  modport slave (
    output redirect, redirect_pc, instr_ready, mem_ack, mem_rdata,
    input  instr, instr_pc, instr_valid, mem_req, mem_addr, stall_count
  );
endinterface

// File: rtl/instr_prefetch.sv
// Instruction prefetch queue: keeps up to DEPTH sequential instructions ahead of the core, one memory request outstanding.
// Latency: data accepted on an ack edge is at instr/instr_valid the next cycle; redirect target requested the next cycle.
// Backpressure: stops requesting when the queue is full; IFETCH_PERF_EN builds the stall_count counter.
module instr_prefetch #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input logic               clk,
  input logic               reset,
  instr_prefetch_if.master  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] fetch_addr_q, fetch_addr_d;
  logic [AW-1:0] target_q, target_d;

  logic [15:0]   buf_instr_q [DEPTH];
  logic [AW-1:0] buf_pc_q    [DEPTH];

  logic push;
  logic pop;
  logic has_room;

  // A redirect suppresses both the push of returned data and any pop by the core.
  assign push = (state_q == REQ) && bus.mem_ack && !bus.redirect;
  assign pop  = (count_q != '0) && bus.instr_ready && !bus.redirect;

  // Queue pointer/count update; redirect empties the queue outright.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  assign has_room = count_d < CW'(DEPTH);

  // Next-state logic: fetch address sequencing, redirect handling and drain of an abandoned request.
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    target_d     = target_q;
    case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          fetch_addr_d = bus.redirect_pc;
          state_d      = REQ;
        end else if (has_room) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          if (bus.mem_ack) begin
            fetch_addr_d = bus.redirect_pc;
          end else begin
            // Request already on the bus must complete at its old address.
            target_d = bus.redirect_pc;
            state_d  = DRAIN;
          end
        end else if (bus.mem_ack) begin
          fetch_addr_d = fetch_addr_q + AW'(1);
          if (!has_room) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (bus.redirect) begin
          target_d = bus.redirect_pc;
        end else if (bus.mem_ack) begin
          fetch_addr_d = target_q;
          state_d      = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fetch_addr_q <= '0;
      target_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fetch_addr_q <= fetch_addr_d;
      target_q     <= target_d;
    end
  end

  // Queue storage; contents are only visible while count is non-zero, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr_q[wr_ptr_q] <= bus.mem_rdata;
      buf_pc_q[wr_ptr_q]    <= fetch_addr_q;
    end
  end

  // Outputs: request is a pure function of state, head entry is masked to zero while empty.
  always_comb begin
    bus.mem_req     = (state_q == REQ) || (state_q == DRAIN);
    bus.mem_addr    = fetch_addr_q;
    bus.instr_valid = (count_q != '0);
    bus.instr       = '0;
    bus.instr_pc    = '0;
    if (count_q != '0) begin
      bus.instr    = buf_instr_q[rd_ptr_q];
      bus.instr_pc = buf_pc_q[rd_ptr_q];
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;

  // Count cycles where the core wants an instruction but the queue is empty; saturates.
  always_comb begin
    stall_count_d = stall_count_q;
    if (bus.instr_ready && (count_q == '0) && (stall_count_q != 32'hFFFF_FFFF))
      stall_count_d = stall_count_q + 32'd1;
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) stall_count_q <= '0;
    else       stall_count_q <= stall_count_d;
  end

  assign bus.stall_count = stall_count_q;
`else
  assign bus.stall_count = '0;
`endif

endmodule
